// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_dump_pkg -- state encoding and accumulator tag helper for reg_dump
// Rev 1.0
// ---------------------------------------------------------------------------
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // Tag value reserved for the accumulator beat: one past the last register.
  function automatic int unsigned acc_tag(input int unsigned d);
    return 32'd1 << d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_dump -- walks a register-file address range and streams each word,
//             then the accumulator, over a valid/ready handshake
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] start_addr,
  input  logic [D-1:0] end_addr,
  output logic [D-1:0] rf_addr,
  input  logic [W-1:0] rf_data,
  input  logic [W-1:0] acc_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [D:0]   out_tag,
  output logic         busy,
  output logic         done
);

  localparam logic [D:0]   ACC_TAG = (D+1)'(acc_tag(D));
  localparam logic [D-1:0] ONE     = D'(1);

  state_t       state;
  state_t       state_nxt;
  logic [D-1:0] idx;
  logic [D-1:0] last;
  logic         acc_phase;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    rf_addr   = idx;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        rf_addr = '0;
        if (start) begin
          state_nxt = READ;
        end
      end
      READ: begin
        state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = acc_phase ? DONE : READ;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The captured beat is frozen at READ; SEND only advances the walk on handshake.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      last      <= '0;
      acc_phase <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= start_addr;
            last      <= end_addr;
            acc_phase <= 1'b0;
          end
        end
        READ: begin
          if (acc_phase) begin
            out_data <= acc_in;
            out_tag  <= ACC_TAG;
          end else begin
            out_data <= rf_data;
            out_tag  <= {1'b0, idx};
          end
        end
        SEND: begin
          if (out_ready && !acc_phase) begin
            if (idx == last) begin
              acc_phase <= 1'b1;
            end else begin
              idx <= idx + ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// tb_reg_dump -- scoreboard bench for reg_dump: expected beats are queued at
// start and popped as the DUT hands them off.
module tb_reg_dump;

  localparam int         W      = 8;
  localparam int         D      = 4;
  localparam logic [D:0] ACC    = 5'd16;
  localparam int         BUDGET = 60;

  typedef struct packed {
    logic [W-1:0] data;
    logic [D:0]   tag;
  } beat_t;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic [D-1:0] start_addr;
  logic [D-1:0] end_addr;
  logic [D-1:0] rf_addr;
  logic [W-1:0] rf_data;
  logic [W-1:0] acc_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [D:0]   out_tag;
  logic         busy;
  logic         done;

  logic [W-1:0] regs [16];
  beat_t        sb[$];
  int           checks = 0;
  int           errors = 0;

  assign rf_data = regs[rf_addr];

  always #5 CLK = ~CLK;

  reg_dump #(.W(W), .D(D)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .acc_in     (acc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected beats: every register from s to e (wrapping), then the accumulator.
  task automatic push_range(input logic [D-1:0] s, input logic [D-1:0] e);
    logic [D-1:0] a;
    a = s;
    forever begin
      sb.push_back('{data: regs[a], tag: {1'b0, a}});
      if (a == e) break;
      a = a + 4'd1;
    end
    sb.push_back('{data: acc_in, tag: ACC});
  endtask

  task automatic start_dump(input logic [D-1:0] s, input logic [D-1:0] e);
    sb.delete();
    push_range(s, e);
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Waits (bounded) for a beat that will handshake at the next edge, then takes it.
  task automatic get_beat(output beat_t b, output int waited, output bit timeout);
    waited  = 0;
    timeout = 1'b0;
    b       = '0;
    while (!(out_valid === 1'b1 && out_ready === 1'b1)) begin
      if (waited >= BUDGET) begin
        timeout = 1'b1;
        return;
      end
      tick();
      waited++;
    end
    b = '{data: out_data, tag: out_tag};
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    start_addr = '0; end_addr = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: valid %b busy %b done %b, want 0 0 0", out_valid, busy, done);
    end
    checks++;
    if (out_data !== 8'h00 || out_tag !== 5'd0 || rf_addr !== 4'd0) begin
      errors++; $display("FAIL reset_data: data %h tag %0d rf_addr %0d, want 00 0 0", out_data, out_tag, rf_addr);
    end
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || rf_addr !== 4'd0) begin
      errors++; $display("FAIL reset_idle: valid %b busy %b rf_addr %0d, want 0 0 0", out_valid, busy, rf_addr);
    end
  endtask

  task automatic test_full_dump();
    beat_t b, exp; int w; bit to;
    start_dump(4'd0, 4'd15);
    for (int i = 0; i < 17; i++) begin
      get_beat(b, w, to);
      checks++;
      if (to) begin errors++; $display("FAIL full_timeout: beat %0d absent after %0d cycles, want handshake", i, BUDGET); break; end
      exp = sb.pop_front();
      checks++;
      if (b !== exp || w !== 1) begin
        errors++; $display("FAIL full_beat %0d: data %h tag %0d gap %0d, want data %h tag %0d gap 1", i, b.data, b.tag, w, exp.data, exp.tag);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL full_done: done %b busy %b, want 1 1", done, busy); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL full_idle: done %b busy %b left %0d, want 0 0 0", done, busy, sb.size());
    end
  endtask

  task automatic test_backpressure();
    beat_t b, exp; int w; bit to;
    start_dump(4'd0, 4'd15);
    for (int i = 0; i < 17; i++) begin
      if (i == 3) begin
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== 8'hA3 || out_tag !== 5'd3) begin
            errors++; $display("FAIL bp_hold %0d: valid %b data %h tag %0d, want 1 a3 3", k, out_valid, out_data, out_tag);
          end
          tick();
        end
        out_ready = 1'b1;
      end
      get_beat(b, w, to);
      checks++;
      if (to) begin errors++; $display("FAIL bp_timeout: beat %0d absent after %0d cycles, want handshake", i, BUDGET); break; end
      exp = sb.pop_front();
      checks++;
      if (b !== exp || w !== ((i == 3) ? 0 : 1)) begin
        errors++; $display("FAIL bp_beat %0d: data %h tag %0d gap %0d, want data %h tag %0d", i, b.data, b.tag, w, exp.data, exp.tag);
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL bp_done: done %b, want 1", done); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL bp_idle: done %b busy %b left %0d, want 0 0 0", done, busy, sb.size());
    end
  endtask

  // Covers both wrap-around (14..1) and single-register (5..5) ranges.
  task automatic test_range(input logic [D-1:0] s, input logic [D-1:0] e, input int n);
    beat_t b, exp; int w; bit to;
    start_dump(s, e);
    checks++;
    if (sb.size() != n) begin errors++; $display("FAIL range_len %0d..%0d: queued %0d, want %0d", s, e, sb.size(), n); end
    for (int i = 0; i < n; i++) begin
      get_beat(b, w, to);
      checks++;
      if (to) begin errors++; $display("FAIL range_timeout %0d..%0d: beat %0d absent, want handshake", s, e, i); break; end
      exp = sb.pop_front();
      checks++;
      if (b !== exp || w !== 1) begin
        errors++; $display("FAIL range_beat %0d..%0d #%0d: data %h tag %0d gap %0d, want data %h tag %0d gap 1", s, e, i, b.data, b.tag, w, exp.data, exp.tag);
      end
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL range_done %0d..%0d: done %b valid %b, want 1 0", s, e, done, out_valid); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL range_idle %0d..%0d: done %b busy %b, want 0 0", s, e, done, busy); end
  endtask

  task automatic test_start_while_busy();
    beat_t b, exp; int w; bit to;
    start_dump(4'd0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start_addr = 4'd9; end_addr = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
      end
      get_beat(b, w, to);
      checks++;
      if (to) begin errors++; $display("FAIL busy_timeout: beat %0d absent, want handshake", i); break; end
      exp = sb.pop_front();
      checks++;
      if (b !== exp || w !== ((i == 2) ? 0 : 1)) begin
        errors++; $display("FAIL busy_beat %0d: data %h tag %0d gap %0d, want data %h tag %0d", i, b.data, b.tag, w, exp.data, exp.tag);
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL busy_done: done %b, want 1", done); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL busy_quiet %0d: done %b valid %b busy %b, want 0 0 0", k, done, out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    beat_t b, exp; int w; bit to;
    start_dump(4'd0, 4'd15);
    for (int i = 0; i < 4; i++) begin
      get_beat(b, w, to);
      checks++;
      if (to) begin errors++; $display("FAIL mid_timeout: beat %0d absent, want handshake", i); break; end
      exp = sb.pop_front();
      checks++;
      if (b !== exp) begin errors++; $display("FAIL mid_beat %0d: data %h tag %0d, want data %h tag %0d", i, b.data, b.tag, exp.data, exp.tag); end
    end
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_abort: valid %b busy %b done %b, want 0 0 0", out_valid, busy, done);
    end
    tick();
    reset = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_quiet %0d: done %b valid %b, want 0 0", k, done, out_valid); end
    end
    test_range(4'd2, 4'd2, 2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'hA0 + 8'(i);
    acc_in = 8'h5C;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_range(4'd14, 4'd1, 5);
    test_range(4'd5, 4'd5, 2);
    test_start_while_busy();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_dump.md
Name: reg_dump

Overview:
- Sequential reader for the register file: on a start pulse, walks an address range through the register file's read port.
- Captures each word and streams it out over a valid/ready handshake, followed by one final beat carrying the accumulator.
- Used for debug readout, testbench state comparison and end-of-program result extraction.
- Sits beside the register file, sharing its read address; never drives its write port.

Parameters:
- W, 8, data path width (matches register file W).
- D, 4, register pointer width; register file depth is 2**D.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a dump; sampled only in IDLE.
- start_addr  input  D  first register to dump; sampled with start.
- end_addr  input  D  last register to dump (inclusive); sampled with start.
- rf_addr  output  D  read address to register file.
- rf_data  input  W  combinational read data from register file.
- acc_in  input  W  accumulator value from register file.
- out_valid  output  1  out_data/out_tag hold a beat.
- out_ready  input  1  consumer accepts beat when out_valid && out_ready.
- out_data  output  W  captured word.
- out_tag  output  D+1  {1'b0, addr} for a register beat; ACC_TAG = 2**D for the accumulator beat.
- busy  output  1  high from the cycle after accepted start until DONE is left.
- done  output  1  one-cycle pulse after the accumulator beat handshakes.

Behaviour:
- Reset (async, any state): state=IDLE; idx=0; rf_addr=0; out_valid=0; out_data=0; out_tag=0; busy=0; done=0.
- States are IDLE, READ, SEND and DONE.
- IDLE:
  - start=1 latches start_addr into idx and end_addr into last, clears acc_phase, then goes to READ.
  - start=0 stays in IDLE.
  - rf_addr=0.
- READ (one cycle):
  - rf_addr=idx.
  - If acc_phase=0: out_data<=rf_data, out_tag<={0,idx}.
  - If acc_phase=1: out_data<=acc_in, out_tag<=ACC_TAG.
  - Next state is SEND.
- SEND:
  - out_valid=1; out_data and out_tag hold stable until the handshake.
  - rf_addr stays at idx.
  - On handshake:
    - If acc_phase=1, go to DONE.
    - Else if idx==last, set acc_phase=1 and go to READ.
    - Else idx<=idx+1 (mod 2**D) and go to READ.
- DONE (one cycle): done=1, then go to IDLE.
- Range and wrap-around:
  - end_addr<start_addr wraps through 2**D-1 to 0.
  - start_addr==end_addr yields exactly one register beat plus the accumulator beat.
  - A full range (e.g. 0..15) yields 2**D+1 beats.
- Throughput: 2 cycles per beat minimum, i.e. 1 READ plus 1 SEND with out_ready high.
- Start timing: start asserted in the cycle before the edge gives READ in the next cycle; the first out_valid follows one cycle later.
- start while busy or in DONE: ignored, not queued.
- Data capture timing: register writes during a dump are visible only if they land before that entry's READ cycle. The captured beat does not change afterward.
- Reset mid-dump: immediate abort, no done pulse, partial beat dropped; the next start works normally.
- out_ready is ignored when out_valid=0.

Decomposition:
- reg_dump_pkg holds:
  - the state enum typedef (IDLE, READ, SEND, DONE);
  - the function acc_tag(D) returning 2**D.
- No sub-module is warranted: one FSM plus an index counter in a single module.

Test Plan:
- Full dump: reset, then start with start_addr=0, end_addr=15, out_ready=1, registers preloaded with value = 8'hA0+i, acc=8'h5C.
  - Expect 17 beats with tags 0..15 then 16 and data A0..AF then 5C.
  - Beats are spaced 2 cycles apart, followed by one done pulse, with busy low afterward.
- Backpressure: same setup, out_ready held low for 5 cycles on beat 3.
  - out_valid stays 1 and out_data=A3/tag 3 stays stable throughout.
  - Sequence continues unchanged when ready rises.
- Wrap range: start_addr=14, end_addr=1.
  - Tags 14,15,0,1,16 with matching data.
- Single register: start_addr=end_addr=5.
  - Tags 5,16 only; done after the second handshake.
- Start while busy: pulse start with start_addr=9 during beat 2 of a 0..3 dump.
  - Ignored: tags 0,1,2,3,16 only, single done.
- Reset mid-dump: assert reset asynchronously after beat 3 handshake.
  - out_valid, busy and done drop to 0 immediately with no done pulse.
  - A following start with 2..2 produces tags 2,16.
